i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEVICE_ADDR, default 7'h76; 7-bit bus address the block responds to.
REQ-002 Parameter SYNC_STAGES, default 2; synchronizer depth on scl_in and sda_in, minimum 2.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scl_in  input  1  raw SCL line, asynchronous to clk.
REQ-006 sda_in  input  1  raw SDA line, asynchronous to clk.
REQ-007 sda_oe  output  1  1 pulls SDA low through the pad's open-drain driver; 0 releases SDA.
REQ-008 wr_valid  output  1  one-cycle strobe; wr_addr/wr_data hold a received register write.
REQ-009 wr_addr  output  8  target register address.
REQ-010 wr_data  output  8  received data byte.
REQ-011 busy  output  1  1 from an addressed START until STOP.

Function
REQ-012 scl_in and sda_in SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized values.
REQ-013 START (SDA falls while SCL high) SHALL enter DEV_ADDR with bit count 0, from any state.
REQ-014 Repeated START SHALL behave identically to START.
REQ-015 STOP (SDA rises while SCL high) SHALL enter IDLE and clear sda_oe and busy, from any state.
REQ-016 States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, DATA, DATA_ACK, IGNORE.
REQ-017 Bits SHALL be sampled MSB first on synchronized SCL rising edges.
REQ-018 A 3-bit counter SHALL count bits; after bit 8, DEV_ADDR/REG_ADDR/DATA move to their ACK state.
REQ-019 Address byte {addr[6:0], rw}: on match with DEVICE_ADDR and rw=0, go to DEV_ACK.
REQ-020 Address mismatch or rw=1 SHALL enter IGNORE: no ACK, and no outputs change until START or STOP.
REQ-021 In any ACK state, sda_oe SHALL assert on the SCL falling edge after bit 8 and release on the next SCL falling edge.
REQ-022 After DEV_ACK, the state SHALL be REG_ADDR; after REG_ACK and DATA_ACK, the state SHALL be DATA.
REQ-023 REG_ADDR completion SHALL load wr_addr.
REQ-024 DATA completion SHALL load wr_data and pulse wr_valid for exactly one clk, within 1 clk of the 8th-bit sample.
REQ-025 After each DATA_ACK, wr_addr SHALL increment by 1 and wrap from 8'hFF to 8'h00.
REQ-026 SDA changes while SCL is high inside a byte SHALL be treated only as START/STOP, never as data.
REQ-027 busy SHALL be 1 in DEV_ACK through DATA_ACK and 0 in IDLE, DEV_ADDR and IGNORE.
REQ-028 sda_oe SHALL never assert outside an ACK state.

Reset
REQ-029 Reset SHALL force state IDLE, and set sda_oe, wr_valid, busy, wr_addr, wr_data and the bit count to 0.
REQ-030 Synchronizer flops SHALL reset to 1, the idle bus level.
REQ-031 Reset mid-transfer SHALL release SDA immediately; the block resumes only on a later START.

Configuration
REQ-032 Macro I2C_TARGET_GLITCH_FILTER_EN: when defined, each synchronized line SHALL pass through a 3-sample majority filter, adding 2 clk latency.
REQ-033 When I2C_TARGET_GLITCH_FILTER_EN is undefined, no filter SHALL be present and lines go straight from the synchronizer to edge detection.

Structure
REQ-034 Shared package i2c_pkg SHALL hold the state encoding, default device address 7'h76 and the ACK/NACK constants.
REQ-035 Sub-module i2c_line_sync SHALL hold the synchronizer, the optional filter and rise/fall detection, and SHALL be instantiated once per line.

Verification
REQ-036 START, 0xEC, 0x49, 0xC0, STOP -> three ACKs; one wr_valid with wr_addr=0x49 and wr_data=0xC0; busy returns to 0.
REQ-037 START, 0xEC, 0xFF, 0x11, 0x22, STOP -> writes (0xFF,0x11) then (0x00,0x22); address wrap verified.
REQ-038 START, 0xA0, 0x12, STOP -> no ACK; sda_oe stays 0; no wr_valid.
REQ-039 START, 0xEC, 0x21, three data bits, repeated START, 0xEC, 0x33, 0x44, STOP -> single write (0x33,0x44); partial byte discarded.
REQ-040 Reset asserted during DEV_ACK with sda_oe=1 -> sda_oe=0 asynchronously; then START, 0xED -> NACK.
REQ-041 With the macro defined, a 1-clk SCL glitch inside a byte -> no extra bit counted and data unchanged; without it -> the glitch counts as a bit.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : State encoding, default address and ACK constants for i2c_target.
// Revision : 1.0
// ============================================================================
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DEV_ADDR = 3'd1,
      ST_DEV_ACK  = 3'd2,
      ST_REG_ADDR = 3'd3,
      ST_REG_ACK  = 3'd4,
      ST_DATA     = 3'd5,
      ST_DATA_ACK = 3'd6,
      ST_IGNORE   = 3'd7
   } i2c_state_e;

   localparam logic [6:0] C_DEFAULT_DEV_ADDR = 7'h76;
   localparam logic       C_RW_WRITE         = 1'b0;

   // sda_oe value that produces an ACK (line pulled low) or a NACK (released)
   localparam logic       C_OE_ACK           = 1'b1;
   localparam logic       C_OE_NACK          = 1'b0;

   function automatic logic state_is_busy(input i2c_state_e s);
      return (s inside {ST_DEV_ACK, ST_REG_ADDR, ST_REG_ACK, ST_DATA, ST_DATA_ACK});
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_target_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_if
// Brief    : Bus pins and register-write strobe bundle of i2c_target.
// Revision : 1.0
// ============================================================================
interface i2c_target_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   modport slave  (input scl_in, sda_in, output sda_oe, wr_valid, wr_addr, wr_data, busy);
   modport master (output scl_in, sda_in, input sda_oe, wr_valid, wr_addr, wr_data, busy);
endinterface
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_line_sync
// Brief    : Synchronizer, optional 3-sample majority filter
//            (I2C_TARGET_GLITCH_FILTER_EN) and edge detect for one line.
// Revision : 1.0
// ============================================================================
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic line_in,
   output logic      level,
   output logic      rise,
   output logic      fall
);
   localparam int C_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [C_STAGES-1:0] sync_q, sync_d;
   logic                prev_q, prev_d;
   logic                sync_out;

   assign sync_out = sync_q[C_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] hist_q, hist_d;
   logic       filt_q, filt_d;

   // A single-cycle pulse is outvoted by the two older samples.
   always_comb begin
      hist_d = {hist_q[0], sync_out};
      filt_d = (sync_out & hist_q[0]) | (sync_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= 2'b11;
         filt_q <= 1'b1;
      end else begin
         hist_q <= hist_d;
         filt_q <= filt_d;
      end
   end

   assign level = filt_q;
`else
   assign level = sync_out;
`endif

   always_comb begin
      sync_d = {sync_q[C_STAGES-2:0], line_in};
      prev_d = level;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = level & ~prev_q;
   assign fall = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Brief    : Write-only I2C register target; I2C_TARGET_GLITCH_FILTER_EN adds
//            a majority filter on SCL/SDA.
// Revision : 1.0
// ============================================================================
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDR = C_DEFAULT_DEV_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input wire logic    clk,
   input wire logic    reset,
   i2c_target_if.slave bus
);
   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;
   logic start_cond, stop_cond;
   logic [7:0] byte_in;

   i2c_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic       sda_oe_q, sda_oe_d;
   logic       wr_valid_q, wr_valid_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       busy_q, busy_d;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk     (clk),
      .reset   (reset),
      .line_in (bus.scl_in),
      .level   (scl),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk     (clk),
      .reset   (reset),
      .line_in (bus.sda_in),
      .level   (sda),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   assign start_cond = scl & sda_fall;
   assign stop_cond  = scl & sda_rise;
   assign byte_in    = {shift_q, sda};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      sda_oe_d   = sda_oe_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      if (stop_cond) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         sda_oe_d  = C_OE_NACK;
      end else if (start_cond) begin
         state_d   = ST_DEV_ADDR;
         bit_cnt_d = 3'd0;
         sda_oe_d  = C_OE_NACK;
      end else begin
         case (state_q)
            ST_DEV_ADDR, ST_REG_ADDR, ST_DATA: begin
               if (scl_rise) begin
                  shift_d   = byte_in[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == ST_DEV_ADDR) begin
                        state_d = (byte_in == {DEVICE_ADDR, C_RW_WRITE}) ? ST_DEV_ACK : ST_IGNORE;
                     end else if (state_q == ST_REG_ADDR) begin
                        wr_addr_d = byte_in;
                        state_d   = ST_REG_ACK;
                     end else begin
                        wr_data_d  = byte_in;
                        wr_valid_d = 1'b1;
                        state_d    = ST_DATA_ACK;
                     end
                  end
               end
            end
            // First SCL fall drives the ACK, the second ends the ACK bit.
            ST_DEV_ACK, ST_REG_ACK, ST_DATA_ACK: begin
               if (scl_fall) begin
                  if (sda_oe_q == C_OE_NACK) begin
                     sda_oe_d = C_OE_ACK;
                  end else begin
                     sda_oe_d  = C_OE_NACK;
                     bit_cnt_d = 3'd0;
                     state_d   = (state_q == ST_DEV_ACK) ? ST_REG_ADDR : ST_DATA;
                     if (state_q == ST_DATA_ACK) begin
                        wr_addr_d = wr_addr_q + 8'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end

      busy_d = state_is_busy(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 7'd0;
         sda_oe_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 8'd0;
         wr_data_q  <= 8'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         sda_oe_q   <= sda_oe_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.sda_oe   = sda_oe_q;
   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target
// Brief    : Bit-banged I2C master driving i2c_target against a byte-level
//            protocol model.
// Revision : 1.0
// ============================================================================
module tb_i2c_target;
   localparam int Q    = 5;
   localparam int HALF = 10;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;

   i2c_target_if ifc ();

   // Open-drain bus: either side can pull SDA low.
   assign ifc.scl_in = m_scl;
   assign ifc.sda_in = m_sda & ~ifc.sda_oe;

   i2c_target #(.DEVICE_ADDR(7'h76), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // ---------------- DUT observers ----------------
   logic [15:0] obs_q[$];
   int          oe_rises   = 0;
   int          wide_cnt   = 0;
   logic        prev_valid = 1'b0;

   always @(negedge clk) begin
      if (ifc.wr_valid) obs_q.push_back({ifc.wr_addr, ifc.wr_data});
      if (ifc.wr_valid && prev_valid) wide_cnt <= wide_cnt + 1;
      prev_valid <= ifc.wr_valid;
   end

   always @(posedge ifc.sda_oe) oe_rises <= oe_rises + 1;

   // ---------------- protocol-level reference model ----------------
   // phase: 0 idle/ignoring, 1 device address, 2 register address, 3 data
   int          mp         = 0;
   logic [7:0]  msh        = 8'd0;
   int          mcnt       = 0;
   bit          m_ack_pend = 1'b0;
   bit          m_nak_pend = 1'b0;
   logic [7:0]  mptr       = 8'd0;
   int          m_acks     = 0;
   logic [15:0] exp_q[$];
   int          obs_rd     = 0;
   int          oe_base    = 0;

   task automatic model_rise(input logic b, output bit slot, output bit acked);
      slot  = 1'b0;
      acked = 1'b0;
      if (m_ack_pend || m_nak_pend) begin
         slot       = 1'b1;
         acked      = m_ack_pend;
         m_ack_pend = 1'b0;
         m_nak_pend = 1'b0;
      end else if (mp != 0) begin
         msh = {msh[6:0], b};
         mcnt++;
         if (mcnt == 8) begin
            mcnt = 0;
            if (mp == 1) begin
               if (msh == 8'hEC) begin
                  mp = 2; m_ack_pend = 1'b1; m_acks++;
               end else begin
                  mp = 0; m_nak_pend = 1'b1;
               end
            end else if (mp == 2) begin
               mptr = msh; mp = 3; m_ack_pend = 1'b1; m_acks++;
            end else begin
               exp_q.push_back({mptr, msh});
               mptr = mptr + 8'd1;
               m_ack_pend = 1'b1; m_acks++;
            end
         end
      end
   endtask

   task automatic model_start();
      mp = 1; mcnt = 0; m_ack_pend = 1'b0; m_nak_pend = 1'b0;
   endtask

   task automatic model_clear();
      mp = 0; mcnt = 0; m_ack_pend = 1'b0; m_nak_pend = 1'b0; m_acks = 0;
      exp_q.delete();
      obs_rd  = obs_q.size();
      oe_base = oe_rises;
   endtask

   // ---------------- bus master ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic raw_rise();
      bit s, a;
      m_scl = 1'b1;
      wait_clk(2);
      model_rise(ifc.sda_in, s, a);
   endtask

   task automatic scl_high_phase();
      logic line;
      bit   slot, acked;
      m_scl = 1'b1;
      wait_clk(2);
      line = ifc.sda_in;
      model_rise(line, slot, acked);
      if (slot) begin
         check("busy_in_ack", ifc.busy, acked);
         if (m_sda) check("ack_level", line, acked ? 0 : 1);
      end
      wait_clk(HALF - 2);
      m_scl = 1'b0;
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      m_sda = b;
      wait_clk(Q);
      scl_high_phase();
      if (glitch) begin
         wait_clk(2);
`ifndef I2C_TARGET_GLITCH_FILTER_EN
         raw_rise();
         wait_clk(1);
`else
         m_scl = 1'b1;
         wait_clk(1);
`endif
         m_scl = 1'b0;
         wait_clk(Q - 3);
      end else begin
         wait_clk(Q);
      end
   endtask

   task automatic send_byte(input logic [7:0] v, input int gpos);
      for (int i = 7; i >= 0; i--) send_bit(v[i], i == gpos);
      send_bit(1'b1, 1'b0);
   endtask

   task automatic start_cond();
      m_sda = 1'b1;
      wait_clk(Q);
      if (!m_scl) raw_rise();
      wait_clk(Q);
      m_sda = 1'b0;
      model_start();
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic stop_cond();
      logic [15:0] e;
      m_sda = 1'b0;
      wait_clk(Q);
      raw_rise();
      wait_clk(Q);
      m_sda = 1'b1;
      wait_clk(Q);
      check("busy_after_stop", ifc.busy, 0);
      check("oe_pulses", oe_rises - oe_base, m_acks);
      check("wr_valid_width", wide_cnt, 0);
      check("write_count", obs_q.size() - obs_rd, exp_q.size());
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
         e = exp_q.pop_front();
         check("wr_addr", obs_q[obs_rd][15:8], e[15:8]);
         check("wr_data", obs_q[obs_rd][7:0], e[7:0]);
         obs_rd++;
      end
      model_clear();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] dev_w;
      logic [7:0] addr_b, reg_b;
      int         kind, nbytes, k;

      wait_clk(4);
      reset = 1'b0;
      wait_clk(2);
      check("rst_sda_oe",   ifc.sda_oe,   0);
      check("rst_wr_valid", ifc.wr_valid, 0);
      check("rst_busy",     ifc.busy,     0);
      check("rst_wr_addr",  ifc.wr_addr,  0);
      check("rst_wr_data",  ifc.wr_data,  0);
      model_clear();

      // basic single write
      start_cond(); send_byte(8'hEC, -1); send_byte(8'h49, -1); send_byte(8'hC0, -1); stop_cond();
      // register pointer wrap
      start_cond(); send_byte(8'hEC, -1); send_byte(8'hFF, -1);
      send_byte(8'h11, -1); send_byte(8'h22, -1); stop_cond();
      // foreign address
      start_cond(); send_byte(8'hA0, -1); send_byte(8'h12, -1); stop_cond();
      // partial byte abandoned by repeated START
      start_cond(); send_byte(8'hEC, -1); send_byte(8'h21, -1);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      start_cond(); send_byte(8'hEC, -1); send_byte(8'h33, -1); send_byte(8'h44, -1); stop_cond();
      // one-clock SCL glitch after the first data bit
      start_cond(); send_byte(8'hEC, -1); send_byte(8'h10, -1);
      send_byte(8'hB5, 7); send_byte(8'h3C, -1); stop_cond();

      // reset while the target is driving the address ACK
      dev_w = 8'hEC;
      start_cond();
      for (int i = 7; i >= 0; i--) send_bit(dev_w[i], 1'b0);
      k = 0;
      while (!ifc.sda_oe && k < 40) begin wait_clk(1); k++; end
      check("oe_before_reset", ifc.sda_oe, 1);
      reset = 1'b1;
      #1;
      check("oe_async_reset", ifc.sda_oe, 0);
      check("busy_async_reset", ifc.busy, 0);
      wait_clk(3);
      reset = 1'b0;
      wait_clk(2);
      model_clear();
      start_cond(); send_byte(8'hED, -1); send_byte(8'h55, -1); stop_cond();

      // randomized traffic
      for (int t = 0; t < 12; t++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            addr_b = 8'($urandom_range(0, 127));
            if (addr_b == 8'h76) addr_b = 8'h75;
            start_cond(); send_byte({addr_b[6:0], 1'($urandom_range(0, 1))}, -1);
            send_byte(8'($urandom), -1); stop_cond();
         end else if (kind == 1) begin
            start_cond(); send_byte(8'hED, -1); send_byte(8'($urandom), -1); stop_cond();
         end else begin
            reg_b  = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
            nbytes = $urandom_range(1, 4);
            start_cond(); send_byte(8'hEC, -1); send_byte(reg_b, -1);
            for (int n = 0; n < nbytes; n++) send_byte(8'($urandom), -1);
            stop_cond();
         end
      end

      wait_clk(10);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
